sm_step_conditioner: RTL

//  Downstream of the stepper pulse generator. Takes its raw drv_pulse train, direction and enable,
//  and drives the external stepper driver (STEP/DIR/EN). Enforces the driver's minimum pulse widths
//  and DIR setup/hold timing, blocks motion into debounced limit switches, and keeps a signed

---
 rtl/sm_step_conditioner.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/sm_step_conditioner.sv
// Conditions a raw step train for an external stepper driver: pulse/DIR timing,
// debounced limit blocking, one-deep request buffering and absolute position.

module sm_step_conditioner #(
    parameter int T_HIGH_MIN  = 100,
    parameter int T_LOW_MIN   = 100,
    parameter int T_DIR_SETUP = 250,
    parameter int T_DIR_HOLD  = 250,
    parameter int DEB_LEN     = 16,
    parameter int POS_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step_in,
    input  logic             dir_in,
    input  logic             drv_en,
    input  logic             lim_fwd,
    input  logic             lim_rev,
    input  logic             pos_clr,
    input  logic             fault_clr,
    output logic             step_out,
    output logic             dir_out,
    output logic             en_out,
    output logic [POS_W-1:0] position,
    output logic             step_drop,
    output logic             lim_fault,
    output logic             busy
);

    localparam int T_LOW      = (T_LOW_MIN > T_DIR_HOLD) ? T_LOW_MIN : T_DIR_HOLD;
    localparam int T_MAX0     = (T_HIGH_MIN > T_LOW) ? T_HIGH_MIN : T_LOW;
    localparam int T_MAX      = (T_DIR_SETUP > T_MAX0) ? T_DIR_SETUP : T_MAX0;
    localparam int CNT_W      = $clog2(T_MAX + 1);
    localparam int SETUP_LAST = (T_DIR_SETUP > 1) ? T_DIR_SETUP - 2 : 0;
    localparam int DEB_W      = $clog2(DEB_LEN + 1);

    typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;

    state_t           state, next_state;
    logic             step_in_q, req_r, req_dir;
    logic             pending, pend_dir;
    logic             take_dir, blocked;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       lim_meta, lim_sync, lim_deb;
    logic [DEB_W-1:0] deb_cnt [2];

    // Bit 0 is the forward switch, bit 1 the reverse switch.
    always_ff @(posedge clk) begin
        if (rst) begin
            lim_meta <= '0;
            lim_sync <= '0;
            lim_deb  <= '0;
            for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
        end else begin
            lim_meta <= {lim_rev, lim_fwd};
            lim_sync <= lim_meta;
            for (int i = 0; i < 2; i++) begin
                if (lim_sync[i] == lim_deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_W'(DEB_LEN - 1)) begin
                    lim_deb[i] <= lim_sync[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // step_out trails the state by one register, so SETUP is one cycle short
    // to keep exactly T_DIR_SETUP cycles between a DIR change and STEP rising.
    always_comb begin
        next_state = state;
        blocked    = 1'b0;
        take_dir   = pending ? pend_dir : req_dir;
        unique case (state)
            IDLE: begin
                if (pending || req_r) begin
                    if (take_dir ? lim_deb[0] : lim_deb[1]) blocked = 1'b1;
                    else if (take_dir != dir_out)             next_state = SETUP;
                    else                                      next_state = HIGH;
                end
            end
            SETUP: if (cnt == CNT_W'(SETUP_LAST))     next_state = HIGH;
            HIGH:  if (cnt == CNT_W'(T_HIGH_MIN - 1)) next_state = LOW;
            LOW:   if (cnt == CNT_W'(T_LOW - 1))      next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (!drv_en) begin
            next_state = IDLE;
            blocked    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            step_in_q <= 1'b0;
            req_r     <= 1'b0;
            req_dir   <= 1'b0;
            pending   <= 1'b0;
            pend_dir  <= 1'b0;
            cnt       <= '0;
            step_out  <= 1'b0;
            dir_out   <= 1'b0;
            en_out    <= 1'b0;
            position  <= '0;
            step_drop <= 1'b0;
            lim_fault <= 1'b0;
        end else begin
            step_in_q <= step_in;
            req_r     <= step_in & ~step_in_q & drv_en;
            req_dir   <= dir_in;
            en_out    <= drv_en;
            step_out  <= (state == HIGH) && drv_en;
            step_drop <= 1'b0;

            if (next_state != state || state == IDLE) cnt <= '0;
            else                                      cnt <= cnt + CNT_W'(1);

            // In IDLE a buffered request is served first; a simultaneous new one takes its slot.
            if (!drv_en) begin
                pending <= 1'b0;
            end else if (state == IDLE) begin
                if (req_r && pending) pend_dir <= req_dir;
                else                  pending  <= 1'b0;
            end else if (req_r) begin
                if (pending) begin
                    step_drop <= 1'b1;
                end else begin
                    pending  <= 1'b1;
                    pend_dir <= req_dir;
                end
            end

            if (state == IDLE && next_state == SETUP) dir_out <= take_dir;

            if (pos_clr)
                position <= '0;
            else if (state != HIGH && next_state == HIGH)
                position <= dir_out ? position + POS_W'(1) : position - POS_W'(1);

            if (blocked)        lim_fault <= 1'b1;
            else if (fault_clr) lim_fault <= 1'b0;
        end
    end

    assign busy = (state != IDLE) || pending;

endmodule
